hazard_sequencer: RTL and testbench

- Pipeline control unit for the 5-stage pipelined RV32I core (F/D/E/M/W).
- Generates operand-forwarding selects, load-use stalls and branch flushes.
- Freezes the pipeline while a data-memory access in M is unacknowledged, and escalates to a sticky halt on memory timeout.
- Drives the stall/flush enables of the Fetch, Decode, Execute, Memory and Writeback pipeline registers, and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_sequencer.sv | 131 +++++++++++++
 tb/tb_hazard_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline hazard control for the 5-stage RV32I core: forwarding selects, load-use stalls,
// branch flushes, memory-wait freeze with sticky timeout halt, and a stall-cycle counter.
module hazard_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [4:0]       i_Rs1D,
    input  logic [4:0]       i_Rs2D,
    input  logic [4:0]       i_Rs1E,
    input  logic [4:0]       i_Rs2E,
    input  logic [4:0]       i_RdE,
    input  logic             i_LoadE,
    input  logic             i_PCSrcE,
    input  logic             i_RegWriteM,
    input  logic [4:0]       i_RdM,
    input  logic             i_RegWriteW,
    input  logic [4:0]       i_RdW,
    input  logic             i_MemReqM,
    input  logic             i_MemReadyM,
    output logic [1:0]       o_ForwardAE,
    output logic [1:0]       o_ForwardBE,
    output logic             o_StallF,
    output logic             o_StallD,
    output logic             o_StallE,
    output logic             o_StallM,
    output logic             o_FlushD,
    output logic             o_FlushE,
    output logic             o_FlushW,
    output logic             o_Halt,
    output logic [CNT_W-1:0] o_StallCycles,
    output logic [1:0]       o_State
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ERROR = 2'b10
    } state_t;

    localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       memwait;
    logic       load_use;

    // Writeback in M is newer than W, so it takes priority on a double match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (i_RegWriteM && (i_RdM != 5'd0) && (i_RdM == rs))
            return 2'b10;
        else if (i_RegWriteW && (i_RdW != 5'd0) && (i_RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign memwait  = i_MemReqM & ~i_MemReadyM;
    assign load_use = i_LoadE & (i_RdE != 5'd0) & ((i_RdE == i_Rs1D) | (i_RdE == i_Rs2D));
    assign o_State  = state;

    always_comb begin
        o_ForwardAE = fwd_sel(i_Rs1E);
        o_ForwardBE = fwd_sel(i_Rs2E);
        o_StallF    = 1'b0;
        o_StallD    = 1'b0;
        o_StallE    = 1'b0;
        o_StallM    = 1'b0;
        o_FlushD    = 1'b0;
        o_FlushE    = 1'b0;
        o_FlushW    = 1'b0;
        // A freeze bubbles W so the held M instruction never writes back twice.
        if ((state == ST_ERROR) || memwait) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_StallE = 1'b1;
            o_StallM = 1'b1;
            o_FlushW = 1'b1;
        end else if (i_PCSrcE) begin
            o_FlushD = 1'b1;
            o_FlushE = 1'b1;
        end else if (load_use) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_FlushE = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state         <= ST_RUN;
            wait_cnt      <= 8'd0;
            o_Halt        <= 1'b0;
            o_StallCycles <= '0;
        end else begin
            if ((o_StallF || o_FlushE) && (o_StallCycles != CNT_MAX))
                o_StallCycles <= o_StallCycles + 1'b1;
            case (state)
                ST_RUN: begin
                    if (memwait) begin
                        state    <= ST_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                ST_WAIT: begin
                    // A ready arriving on the timeout boundary still completes normally.
                    if (!memwait) begin
                        state    <= ST_RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state  <= ST_ERROR;
                        o_Halt <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_ERROR: begin
                    state  <= ST_ERROR;
                    o_Halt <= 1'b1;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: three instances (default, short timeout, narrow counter) share
// stimulus; a rule-level model tracks consecutive wait cycles, halt and stall counts.
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       loade, pcsrce, regwm, regww, memreq, memrdy;

    logic [1:0]  fwda_a, fwdb_a, fwda_b, fwdb_b, fwda_c, fwdb_c;
    logic        sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a, halt_a;
    logic        sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b, halt_b;
    logic        sf_c, sd_c, se_c, sm_c, fd_c, fe_c, fw_c, halt_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;
    logic [1:0]  state_a, state_b, state_c;
    logic [6:0]  ctl_a, ctl_b;

    assign ctl_a = {sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a};
    assign ctl_b = {sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b};

    int n_cmp = 0;
    int n_err = 0;

    // Model state, index 0: default, 1: TIMEOUT=4, 2: CNT_W=4/TIMEOUT=255
    int m_wait [3];
    bit m_halt [3];
    int m_cnt  [3];
    int tmo    [3] = '{16, 4, 255};
    int cmax   [3] = '{65535, 65535, 15};
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_sequencer dut_a (
        .i_Clk(clk), .i_Reset(rst_n), .i_Rs1D(rs1d), .i_Rs2D(rs2d), .i_Rs1E(rs1e),
        .i_Rs2E(rs2e), .i_RdE(rde), .i_LoadE(loade), .i_PCSrcE(pcsrce),
        .i_RegWriteM(regwm), .i_RdM(rdm), .i_RegWriteW(regww), .i_RdW(rdw),
        .i_MemReqM(memreq), .i_MemReadyM(memrdy), .o_ForwardAE(fwda_a), .o_ForwardBE(fwdb_a),
        .o_StallF(sf_a), .o_StallD(sd_a), .o_StallE(se_a), .o_StallM(sm_a),
        .o_FlushD(fd_a), .o_FlushE(fe_a), .o_FlushW(fw_a), .o_Halt(halt_a),
        .o_StallCycles(cnt_a), .o_State(state_a));

    hazard_sequencer #(.TIMEOUT(4), .CNT_W(16)) dut_b (
        .i_Clk(clk), .i_Reset(rst_n), .i_Rs1D(rs1d), .i_Rs2D(rs2d), .i_Rs1E(rs1e),
        .i_Rs2E(rs2e), .i_RdE(rde), .i_LoadE(loade), .i_PCSrcE(pcsrce),
        .i_RegWriteM(regwm), .i_RdM(rdm), .i_RegWriteW(regww), .i_RdW(rdw),
        .i_MemReqM(memreq), .i_MemReadyM(memrdy), .o_ForwardAE(fwda_b), .o_ForwardBE(fwdb_b),
        .o_StallF(sf_b), .o_StallD(sd_b), .o_StallE(se_b), .o_StallM(sm_b),
        .o_FlushD(fd_b), .o_FlushE(fe_b), .o_FlushW(fw_b), .o_Halt(halt_b),
        .o_StallCycles(cnt_b), .o_State(state_b));

    hazard_sequencer #(.TIMEOUT(255), .CNT_W(4)) dut_c (
        .i_Clk(clk), .i_Reset(rst_n), .i_Rs1D(rs1d), .i_Rs2D(rs2d), .i_Rs1E(rs1e),
        .i_Rs2E(rs2e), .i_RdE(rde), .i_LoadE(loade), .i_PCSrcE(pcsrce),
        .i_RegWriteM(regwm), .i_RdM(rdm), .i_RegWriteW(regww), .i_RdW(rdw),
        .i_MemReqM(memreq), .i_MemReadyM(memrdy), .o_ForwardAE(fwda_c), .o_ForwardBE(fwdb_c),
        .o_StallF(sf_c), .o_StallD(sd_c), .o_StallE(se_c), .o_StallM(sm_c),
        .o_FlushD(fd_c), .o_FlushE(fe_c), .o_FlushW(fw_c), .o_Halt(halt_c),
        .o_StallCycles(cnt_c), .o_State(state_c));

    // ---------------- reference model ----------------
    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (regwm && rdm != 0 && rdm == rs) return 2'b10;
        if (regww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    function automatic logic [6:0] exp_ctl(input bit halted);
        bit mw, lu;
        mw = memreq && !memrdy;
        lu = loade && rde != 0 && (rde == rs1d || rde == rs2d);
        if (halted || mw) return 7'b1111_001;
        if (pcsrce)       return 7'b0000_110;
        if (lu)           return 7'b1100_010;
        return 7'b0000_000;
    endfunction

    function automatic logic [1:0] exp_state(input int i);
        if (m_halt[i]) return 2'b10;
        if (m_wait[i] > 0) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_wait[i] = 0;
            m_halt[i] = 0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_tick();
        logic [6:0] c;
        for (int i = 0; i < 3; i++) begin
            c = exp_ctl(m_halt[i]);
            if ((c[6] || c[1]) && m_cnt[i] < cmax[i]) m_cnt[i]++;
            if (!m_halt[i]) begin
                if (memreq && !memrdy) begin
                    m_wait[i]++;
                    if (m_wait[i] >= tmo[i]) m_halt[i] = 1;
                end else begin
                    m_wait[i] = 0;
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_idle();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        loade = 0; pcsrce = 0; regwm = 0; regww = 0; memreq = 0; memrdy = 0;
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        do_reset();
        #1;
        n_cmp++; if (halt_a !== 1'b0) begin n_err++; $display("FAIL reset_halt got %b want 0", halt_a); end
        n_cmp++; if (cnt_a !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", cnt_a); end
        n_cmp++; if (state_a !== 2'b00) begin n_err++; $display("FAIL reset_state got %b want 00", state_a); end
        n_cmp++; if (ctl_a !== 7'b0) begin n_err++; $display("FAIL reset_ctl got %b want 0000000", ctl_a); end
    endtask

    task automatic test_forwarding();
        set_idle();
        regwm = 1; rdm = 5; regww = 1; rdw = 5; rs1e = 5;
        #1;
        n_cmp++; if (fwda_a !== 2'b10) begin n_err++; $display("FAIL fwd_m_prio got %b want 10", fwda_a); end
        tick();
        rdm = 0;
        #1;
        n_cmp++; if (fwda_a !== 2'b01) begin n_err++; $display("FAIL fwd_w got %b want 01", fwda_a); end
        tick();
        regwm = 1; rdm = 0; rdw = 0; rs1e = 0;
        #1;
        n_cmp++; if (fwda_a !== 2'b00) begin n_err++; $display("FAIL fwd_x0 got %b want 00", fwda_a); end
        tick();
        for (int k = 0; k < 40; k++) begin
            regwm = 1'($urandom_range(0, 1)); regww = 1'($urandom_range(0, 1));
            rdm = 5'($urandom_range(0, 3));   rdw = 5'($urandom_range(0, 3));
            rs1e = 5'($urandom_range(0, 3));  rs2e = 5'($urandom_range(0, 3));
            #1;
            n_cmp++; if (fwda_a !== exp_fwd(rs1e)) begin n_err++; $display("FAIL fwd_rand_a got %b want %b", fwda_a, exp_fwd(rs1e)); end
            n_cmp++; if (fwdb_a !== exp_fwd(rs2e)) begin n_err++; $display("FAIL fwd_rand_b got %b want %b", fwdb_a, exp_fwd(rs2e)); end
            tick();
        end
    endtask

    task automatic test_load_use();
        set_idle();
        do_reset();
        loade = 1; rde = 7; rs2d = 7;
        #1;
        n_cmp++; if (ctl_a !== 7'b1100_010) begin n_err++; $display("FAIL load_use_ctl got %b want 1100010", ctl_a); end
        tick();
        loade = 0;
        #1;
        n_cmp++; if (ctl_a !== 7'b0) begin n_err++; $display("FAIL load_use_after got %b want 0000000", ctl_a); end
        n_cmp++; if (cnt_a !== 16'd1) begin n_err++; $display("FAIL load_use_cnt got %0d want 1", cnt_a); end
        tick();
    endtask

    task automatic test_branch_load_use();
        set_idle();
        loade = 1; rde = 9; rs1d = 9; pcsrce = 1;
        #1;
        n_cmp++; if (ctl_a !== 7'b0000_110) begin n_err++; $display("FAIL branch_lu_ctl got %b want 0000110", ctl_a); end
        tick();
        set_idle();
    endtask

    task automatic test_mem_wait();
        set_idle();
        do_reset();
        memreq = 1; memrdy = 0; pcsrce = 1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_cmp++; if (ctl_a !== 7'b1111_001) begin n_err++; $display("FAIL wait_ctl[%0d] got %b want 1111001", k, ctl_a); end
            n_cmp++; if (state_a !== ((k == 1) ? 2'b00 : 2'b01)) begin n_err++; $display("FAIL wait_state[%0d] got %b", k, state_a); end
            tick();
        end
        n_cmp++; if (cnt_a !== 16'd3) begin n_err++; $display("FAIL wait_cnt got %0d want 3", cnt_a); end
        memrdy = 1;
        #1;
        n_cmp++; if (ctl_a !== 7'b0000_110) begin n_err++; $display("FAIL wait_branch got %b want 0000110", ctl_a); end
        n_cmp++; if (state_a !== 2'b01) begin n_err++; $display("FAIL wait_ready_state got %b want 01", state_a); end
        tick();
        set_idle();
        #1;
        n_cmp++; if (state_a !== 2'b00) begin n_err++; $display("FAIL wait_back_run got %b want 00", state_a); end
        n_cmp++; if (cnt_a !== 16'd4) begin n_err++; $display("FAIL wait_cnt_final got %0d want 4", cnt_a); end
        tick();
    endtask

    task automatic test_timeout();
        // Ready on the 4th waiting cycle must win over the timeout
        set_idle();
        do_reset();
        memreq = 1; memrdy = 0;
        for (int k = 0; k < 3; k++) tick();
        memrdy = 1;
        #1;
        n_cmp++; if (ctl_b !== 7'b0) begin n_err++; $display("FAIL tmo_edge_ctl got %b want 0000000", ctl_b); end
        tick();
        #1;
        n_cmp++; if (state_b !== 2'b00) begin n_err++; $display("FAIL tmo_edge_state got %b want 00", state_b); end
        n_cmp++; if (halt_b !== 1'b0) begin n_err++; $display("FAIL tmo_edge_halt got %b want 0", halt_b); end
        memrdy = 0; pcsrce = 1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_cmp++; if (halt_b !== 1'b0) begin n_err++; $display("FAIL tmo_early_halt[%0d] got %b want 0", k, halt_b); end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            memrdy = 1'(k % 2);
            #1;
            n_cmp++; if (halt_b !== 1'b1) begin n_err++; $display("FAIL tmo_halt[%0d] got %b want 1", k, halt_b); end
            n_cmp++; if (state_b !== 2'b10) begin n_err++; $display("FAIL tmo_state[%0d] got %b want 10", k, state_b); end
            n_cmp++; if (ctl_b !== 7'b1111_001) begin n_err++; $display("FAIL tmo_ctl[%0d] got %b want 1111001", k, ctl_b); end
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (halt_b !== 1'b0) begin n_err++; $display("FAIL tmo_async_halt got %b want 0", halt_b); end
        n_cmp++; if (state_b !== 2'b00) begin n_err++; $display("FAIL tmo_async_state got %b want 00", state_b); end
        n_cmp++; if (cnt_b !== 16'd0) begin n_err++; $display("FAIL tmo_async_cnt got %0d want 0", cnt_b); end
        model_reset();
        set_idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        set_idle();
        do_reset();
        memreq = 1; memrdy = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            #1;
            n_cmp++; if (int'(cnt_c) !== ((k < 15) ? k : 15)) begin n_err++; $display("FAIL sat_cnt[%0d] got %0d want %0d", k, cnt_c, (k < 15) ? k : 15); end
        end
        n_cmp++; if (state_c !== 2'b01) begin n_err++; $display("FAIL sat_state got %b want 01", state_c); end
        set_idle();
        tick();
    endtask

    task automatic test_random();
        logic [6:0] e;
        set_idle();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if (k % 150 == 149) begin
                set_idle();
                do_reset();
            end
            rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
            rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
            rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
            rdw  = 5'($urandom_range(0, 3));
            loade  = 1'($urandom_range(0, 2) == 0);
            pcsrce = 1'($urandom_range(0, 4) == 0);
            regwm  = 1'($urandom_range(0, 1));
            regww  = 1'($urandom_range(0, 1));
            memreq = 1'($urandom_range(0, 2) == 0);
            memrdy = 1'($urandom_range(0, 2) != 0);
            exp_q.push_back(exp_ctl(m_halt[0]));
            #1;
            e = exp_q.pop_front();
            n_cmp++; if (ctl_a !== e) begin n_err++; $display("FAIL rnd_ctl_a[%0d] got %b want %b", k, ctl_a, e); end
            n_cmp++; if (fwda_a !== exp_fwd(rs1e) || fwdb_a !== exp_fwd(rs2e)) begin n_err++; $display("FAIL rnd_fwd[%0d] got %b/%b want %b/%b", k, fwda_a, fwdb_a, exp_fwd(rs1e), exp_fwd(rs2e)); end
            n_cmp++; if (state_a !== exp_state(0) || halt_a !== m_halt[0]) begin n_err++; $display("FAIL rnd_state_a[%0d] got %b/%b want %b/%b", k, state_a, halt_a, exp_state(0), m_halt[0]); end
            n_cmp++; if (int'(cnt_a) !== m_cnt[0]) begin n_err++; $display("FAIL rnd_cnt_a[%0d] got %0d want %0d", k, cnt_a, m_cnt[0]); end
            n_cmp++; if (ctl_b !== exp_ctl(m_halt[1])) begin n_err++; $display("FAIL rnd_ctl_b[%0d] got %b want %b", k, ctl_b, exp_ctl(m_halt[1])); end
            n_cmp++; if (state_b !== exp_state(1) || halt_b !== m_halt[1]) begin n_err++; $display("FAIL rnd_state_b[%0d] got %b/%b want %b/%b", k, state_b, halt_b, exp_state(1), m_halt[1]); end
            n_cmp++; if (int'(cnt_c) !== m_cnt[2]) begin n_err++; $display("FAIL rnd_cnt_c[%0d] got %0d want %0d", k, cnt_c, m_cnt[2]); end
            tick();
        end
        set_idle();
    endtask

    initial begin
        rst_n = 1'b1;
        set_idle();
        model_reset();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
